// File: rtl/cmult_arb.sv
// Two-requester front end sharing one pipelined complex multiplier.
// Fair round-robin on contention; a 6-deep tag pipe routes each product back to its owner.

module cmult #(
  parameter int AWIDTH = 16,
  parameter int BWIDTH = 18
) (
  input  logic                          clk,
  input  logic signed [AWIDTH-1:0]      ar,
  input  logic signed [AWIDTH-1:0]      ai,
  input  logic signed [BWIDTH-1:0]      br,
  input  logic signed [BWIDTH-1:0]      bi,
  output logic signed [AWIDTH+BWIDTH:0] pr,
  output logic signed [AWIDTH+BWIDTH:0] pi
);
  localparam int PW  = AWIDTH + BWIDTH + 1;
  localparam int DLY = 4;

  logic signed [AWIDTH-1:0] ar_q, ai_q;
  logic signed [BWIDTH-1:0] br_q, bi_q;
  logic signed [PW-2:0]     rr_q, ii_q, ri_q, ir_q;
  logic signed [PW-2:0]     rr_d, ii_d, ri_d, ir_d;
  logic signed [PW-1:0]     pr_q [DLY];
  logic signed [PW-1:0]     pi_q [DLY];
  logic signed [PW-1:0]     pr_d [DLY];
  logic signed [PW-1:0]     pi_d [DLY];

  // Register inputs, form partial products, sum, then pad to six stages total.
  always_comb begin
    rr_d = (PW-1)'(ar_q) * (PW-1)'(br_q);
    ii_d = (PW-1)'(ai_q) * (PW-1)'(bi_q);
    ri_d = (PW-1)'(ar_q) * (PW-1)'(bi_q);
    ir_d = (PW-1)'(ai_q) * (PW-1)'(br_q);
    pr_d[0] = PW'(rr_q) - PW'(ii_q);
    pi_d[0] = PW'(ri_q) + PW'(ir_q);
    for (int i = 1; i < DLY; i++) begin
      pr_d[i] = pr_q[i-1];
      pi_d[i] = pi_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    ar_q <= ar;
    ai_q <= ai;
    br_q <= br;
    bi_q <= bi;
    rr_q <= rr_d;
    ii_q <= ii_d;
    ri_q <= ri_d;
    ir_q <= ir_d;
    pr_q <= pr_d;
    pi_q <= pi_d;
  end

  assign pr = pr_q[DLY-1];
  assign pi = pi_q[DLY-1];
endmodule

module cmult_arb #(
  parameter int AWIDTH = 16,
  parameter int BWIDTH = 18,
  parameter int UWIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          s0_valid,
  output logic                          s0_ready,
  input  logic signed [AWIDTH-1:0]      s0_ar,
  input  logic signed [AWIDTH-1:0]      s0_ai,
  input  logic signed [BWIDTH-1:0]      s0_br,
  input  logic signed [BWIDTH-1:0]      s0_bi,
  input  logic        [UWIDTH-1:0]      s0_user,
  input  logic                          s1_valid,
  output logic                          s1_ready,
  input  logic signed [AWIDTH-1:0]      s1_ar,
  input  logic signed [AWIDTH-1:0]      s1_ai,
  input  logic signed [BWIDTH-1:0]      s1_br,
  input  logic signed [BWIDTH-1:0]      s1_bi,
  input  logic        [UWIDTH-1:0]      s1_user,
  output logic                          m0_valid,
  output logic signed [AWIDTH+BWIDTH:0] m0_pr,
  output logic signed [AWIDTH+BWIDTH:0] m0_pi,
  output logic        [UWIDTH-1:0]      m0_user,
  output logic                          m1_valid,
  output logic signed [AWIDTH+BWIDTH:0] m1_pr,
  output logic signed [AWIDTH+BWIDTH:0] m1_pi,
  output logic        [UWIDTH-1:0]      m1_user,
  output logic                          busy
);
  localparam int PW  = AWIDTH + BWIDTH + 1;
  localparam int LAT = 6;

  logic                     pick0, grant0, grant1, xfer;
  logic                     last_s1_q, last_s1_d;
  logic signed [AWIDTH-1:0] mul_ar, mul_ai;
  logic signed [BWIDTH-1:0] mul_br, mul_bi;
  logic signed [PW-1:0]     cm_pr, cm_pi;
  logic [LAT-1:0]           tag_vld_q, tag_vld_d;
  logic [LAT-1:0]           tag_own_q, tag_own_d;
  logic [UWIDTH-1:0]        tag_user_q [LAT];
  logic [UWIDTH-1:0]        tag_user_d [LAT];
  logic                     m0_valid_q, m0_valid_d, m1_valid_q, m1_valid_d;
  logic signed [PW-1:0]     m0_pr_q, m0_pr_d, m0_pi_q, m0_pi_d;
  logic signed [PW-1:0]     m1_pr_q, m1_pr_d, m1_pi_q, m1_pi_d;
  logic [UWIDTH-1:0]        m0_user_q, m0_user_d, m1_user_q, m1_user_d;

  // Grants are gated by rst_n so neither ready can rise while the block is held in reset.
  always_comb begin
    pick0     = s0_valid && (!s1_valid || last_s1_q);
    grant0    = pick0 && rst_n;
    grant1    = s1_valid && !pick0 && rst_n;
    xfer      = grant0 || grant1;
    last_s1_d = xfer ? grant1 : last_s1_q;
    mul_ar    = grant1 ? s1_ar : s0_ar;
    mul_ai    = grant1 ? s1_ai : s0_ai;
    mul_br    = grant1 ? s1_br : s0_br;
    mul_bi    = grant1 ? s1_bi : s0_bi;
  end

  cmult #(.AWIDTH(AWIDTH), .BWIDTH(BWIDTH)) u_cmult (
    .clk (clk),
    .ar  (mul_ar),
    .ai  (mul_ai),
    .br  (mul_br),
    .bi  (mul_bi),
    .pr  (cm_pr),
    .pi  (cm_pi)
  );

  // The tag pipe is as deep as the multiplier, so its last stage lines up with cm_pr/cm_pi.
  always_comb begin
    tag_vld_d     = {tag_vld_q[LAT-2:0], xfer};
    tag_own_d     = {tag_own_q[LAT-2:0], grant1};
    tag_user_d[0] = grant1 ? s1_user : s0_user;
    for (int i = 1; i < LAT; i++) tag_user_d[i] = tag_user_q[i-1];
    m0_valid_d = tag_vld_q[LAT-1] && !tag_own_q[LAT-1];
    m1_valid_d = tag_vld_q[LAT-1] && tag_own_q[LAT-1];
    m0_pr_d    = m0_valid_d ? cm_pr : m0_pr_q;
    m0_pi_d    = m0_valid_d ? cm_pi : m0_pi_q;
    m0_user_d  = m0_valid_d ? tag_user_q[LAT-1] : m0_user_q;
    m1_pr_d    = m1_valid_d ? cm_pr : m1_pr_q;
    m1_pi_d    = m1_valid_d ? cm_pi : m1_pi_q;
    m1_user_d  = m1_valid_d ? tag_user_q[LAT-1] : m1_user_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_s1_q  <= 1'b1;
      tag_vld_q  <= '0;
      tag_own_q  <= '0;
      tag_user_q <= '{default: '0};
      m0_valid_q <= 1'b0;
      m1_valid_q <= 1'b0;
      m0_pr_q    <= '0;
      m0_pi_q    <= '0;
      m0_user_q  <= '0;
      m1_pr_q    <= '0;
      m1_pi_q    <= '0;
      m1_user_q  <= '0;
    end else begin
      last_s1_q  <= last_s1_d;
      tag_vld_q  <= tag_vld_d;
      tag_own_q  <= tag_own_d;
      tag_user_q <= tag_user_d;
      m0_valid_q <= m0_valid_d;
      m1_valid_q <= m1_valid_d;
      m0_pr_q    <= m0_pr_d;
      m0_pi_q    <= m0_pi_d;
      m0_user_q  <= m0_user_d;
      m1_pr_q    <= m1_pr_d;
      m1_pi_q    <= m1_pi_d;
      m1_user_q  <= m1_user_d;
    end
  end

  assign s0_ready = grant0;
  assign s1_ready = grant1;
  assign m0_valid = m0_valid_q;
  assign m0_pr    = m0_pr_q;
  assign m0_pi    = m0_pi_q;
  assign m0_user  = m0_user_q;
  assign m1_valid = m1_valid_q;
  assign m1_pr    = m1_pr_q;
  assign m1_pi    = m1_pi_q;
  assign m1_user  = m1_user_q;
  assign busy     = (|tag_vld_q) || xfer;
endmodule

// File: doc/cmult_arb.md
CMULT_ARB -- requirements
Module: cmult_arb

Interface
Parameters:
REQ-001 The block SHALL have parameter AWIDTH, default 16, giving the a-operand real/imag width.
REQ-002 The block SHALL have parameter BWIDTH, default 18, giving the b-operand real/imag width.
REQ-003 The block SHALL have parameter UWIDTH, default 8, giving the sideband tag width carried with each request.

Ports:
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have ports s0_valid (input, 1) and s0_ready (output, 1): requester 0 handshake.
REQ-007 The block SHALL have ports s0_ar and s0_ai (input, AWIDTH, signed), s0_br and s0_bi (input, BWIDTH, signed), and s0_user (input, UWIDTH): requester 0 operands and tag.
REQ-008 The block SHALL have ports s1_valid, s1_ready, s1_ar, s1_ai, s1_br, s1_bi and s1_user, identical to the s0_* ports, for requester 1.
REQ-009 The block SHALL have ports m0_valid (output, 1), m0_pr and m0_pi (output, AWIDTH+BWIDTH+1, signed) and m0_user (output, UWIDTH): requester 0 result.
REQ-010 The block SHALL have ports m1_valid, m1_pr, m1_pi and m1_user, identical to the m0_* ports, for requester 1.
REQ-011 The block SHALL have port busy, output, 1 bit: high while any accepted request has not yet produced its result.

Function
REQ-012 The block SHALL instantiate exactly one cmult (AWIDTH, BWIDTH), a 6-cycle-latency complex multiplier with no reset, and share it between the two requesters.
REQ-013 Arbitration SHALL be combinational within a cycle: only s0 valid -> grant s0; only s1 valid -> grant s1; both valid -> grant the requester not granted last; neither -> no grant.
REQ-014 sK_ready SHALL equal grant to K, so at most one ready is high per cycle and ready never asserts without the matching valid.
REQ-015 A transfer SHALL occur when sK_valid and sK_ready are high in the same cycle, and the granted operands SHALL be muxed onto the cmult inputs in that cycle.
REQ-016 The last-granted pointer SHALL update only on a transfer, and SHALL reset to "s1 last" so that s0 wins the first contention.
REQ-017 A 6-stage tag pipeline SHALL carry {valid, owner, user} for each issue, in lockstep with cmult.
REQ-018 Output registers SHALL capture cmult pr/pi and the tag user into mK_* only for the owning K when the tag valid exits the pipeline; otherwise they SHALL hold their value.
REQ-019 Latency SHALL be 7 cycles: a transfer in cycle N gives mK_valid high in cycle N+7, for exactly one cycle per transfer.
REQ-020 Throughput SHALL be one transfer per cycle total; back-to-back alternating or single-requester streams SHALL sustain 1 result per cycle.
REQ-021 Results SHALL have no backpressure; mK_valid is a strobe and requesters SHALL sink every result.
REQ-022 Per-requester result order SHALL equal its acceptance order.
REQ-023 Arithmetic SHALL be full precision, pr = ar*br - ai*bi and pi = ar*bi + ai*br, AWIDTH+BWIDTH+1 bits signed, with no rounding or saturation.
REQ-024 busy SHALL be the OR of the tag-pipeline valid bits and the cycle's transfer.

Reset
REQ-025 On rst_n low, all tag valid bits, m0_valid and m1_valid SHALL clear immediately (asynchronously).
REQ-026 On rst_n low, m*_pr, m*_pi and m*_user SHALL reset to 0, and the pointer SHALL reset to "s1 last".
REQ-027 Requests in flight at reset SHALL be discarded, and no mK_valid SHALL appear for them after release.
REQ-028 The sK_ready outputs SHALL be low while rst_n is low.
REQ-029 The first transfer SHALL be possible in the first cycle after rst_n deasserts.

Verification
REQ-030 Scenario: s0 sends (1+2i)*(3+4i), user=0x11, in cycle N -> m0_valid in N+7 with pr=-5, pi=10, user=0x11; m1_valid stays low.
REQ-031 Scenario: both valid continuously for 8 cycles -> grants alternate s0,s1,s0,... starting with s0, and each port receives 4 results in order.
REQ-032 Scenario: s0 sends (-32768-32768i)*(-131072+0i) -> pr=4294967296, pi=4294967296, with no overflow.
REQ-033 Scenario: only s1 valid for 10 cycles -> s1_ready high every cycle and 10 consecutive m1_valid strobes from N+7.
REQ-034 Scenario: assert rst_n low with 3 requests in flight -> m*_valid low immediately, outputs 0, and no stale strobes after release.
REQ-035 Scenario: s0 valid only in cycle N while s1 is valid from N onward -> s0 granted in N (pointer at reset), s1 granted from N+1, and busy stays high until N+8.
